// File: rtl/tone_pkg.sv
// Shared FSM state type and derived constants for the queued tone player.
package tone_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV,
        PLAY,
        GAP
    } state_t;

    localparam int DIV_W = 32;

    function automatic int ms_ticks(input int clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, DIV_W-bit dividend by HZ_W-bit divisor, one quotient bit per cycle.
// The first bit resolves on the start edge, so done rises DIV_W-1 edges after start.
module seq_divider
    import tone_pkg::*;
#(
    parameter int HZ_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] dividend,
    input  logic [HZ_W-1:0]  divisor,
    output logic [DIV_W-1:0] quotient,
    output logic             done
);
    localparam int CW = $clog2(DIV_W) + 1;

    logic [HZ_W-1:0]  rem_q, dvs_q, src_rem, src_dvs, nxt_rem;
    logic [DIV_W-1:0] quo_q, src_quo, nxt_quo;
    logic [HZ_W:0]    trial;
    logic             ge, run_q;
    logic [CW-1:0]    cnt_q;

    // The remainder stays below the divisor, so HZ_W bits hold it between steps.
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_dvs = start ? divisor : dvs_q;
        trial   = {src_rem, src_quo[DIV_W-1]};
        ge      = trial >= {1'b0, src_dvs};
        nxt_rem = ge ? HZ_W'(trial - {1'b0, src_dvs}) : trial[HZ_W-1:0];
        nxt_quo = {src_quo[DIV_W-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            dvs_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            done  <= 1'b0;
        end else if (abort) begin
            run_q <= 1'b0;
            done  <= 1'b0;
        end else if (start) begin
            rem_q <= nxt_rem;
            quo_q <= nxt_quo;
            dvs_q <= divisor;
            cnt_q <= CW'(1);
            run_q <= 1'b1;
            done  <= 1'b0;
        end else if (run_q) begin
            rem_q <= nxt_rem;
            quo_q <= nxt_quo;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(DIV_W - 1)) begin
                run_q <= 1'b0;
                done  <= 1'b1;
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/tone_queue_player.sv
// Queued square-wave tone player: (hz, ms) notes through a FIFO, played back to back.
// Define NOTE_GAP_EN to insert GAP_MS of silence after every played or rest note.
module tone_queue_player
    import tone_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int HZ_W   = 12,
    parameter int DUR_W  = 16,
    parameter int DEPTH  = 8,
    parameter int GAP_MS = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       note_valid,
    output logic                       note_ready,
    input  logic [HZ_W-1:0]            note_hz,
    input  logic [DUR_W-1:0]           note_ms,
    input  logic                       stop,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       note_done,
    output logic                       buzzer
);
    localparam int AW       = $clog2(DEPTH);
    localparam int LW       = $clog2(DEPTH + 1);
    localparam int MS_TICKS = ms_ticks(CLK_HZ);
    localparam logic [DIV_W-1:0] HALF_CLK = DIV_W'(CLK_HZ / 2);
`ifdef NOTE_GAP_EN
    localparam logic [DIV_W-1:0] GAP_TICKS = DIV_W'(GAP_MS * MS_TICKS);
`endif

    if (CLK_HZ < 2000 || (CLK_HZ % 2) != 0 || GAP_MS < 0 || DEPTH < 2 ||
        (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
        $error("tone_queue_player: unsupported CLK_HZ/DEPTH/GAP_MS");
    end

    // FIFO: the extra pointer bit separates full from empty.
    logic [HZ_W+DUR_W-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic                  full, empty, push, pop;
    logic [HZ_W+DUR_W-1:0] head;
    logic [HZ_W-1:0]       head_hz;
    logic [DUR_W-1:0]      head_ms;

    state_t                state;
    logic [DUR_W-1:0]      ms_left;
    logic [DIV_W-1:0]      half, half_cnt, div_q;
    logic [31:0]           ms_pre;
    logic                  mute, div_start, div_done;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign note_ready = rst_n && !full && !stop;
    assign push       = note_valid && note_ready;
    assign pop        = (state == LOAD) && !stop;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign head_hz    = head[HZ_W+DUR_W-1:DUR_W];
    assign head_ms    = head[DUR_W-1:0];
    assign level      = LW'(wr_ptr - rd_ptr);
    assign busy       = (state != IDLE) || !empty;
    assign div_start  = pop && (head_ms != '0) && (head_hz != '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {note_hz, note_ms};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (stop) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    seq_divider #(.HZ_W(HZ_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .abort    (stop),
        .dividend (HALF_CLK),
        .divisor  (head_hz),
        .quotient (div_q),
        .done     (div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ms_left   <= '0;
            half      <= DIV_W'(1);
            half_cnt  <= '0;
            ms_pre    <= '0;
            mute      <= 1'b0;
            buzzer    <= 1'b0;
            note_done <= 1'b0;
        end else if (stop) begin
            state     <= IDLE;
            buzzer    <= 1'b0;
            note_done <= 1'b0;
        end else begin
            note_done <= 1'b0;
            case (state)
                IDLE: if (!empty) state <= LOAD;
                LOAD: begin
                    ms_left  <= head_ms;
                    half_cnt <= '0;
                    ms_pre   <= '0;
                    buzzer   <= 1'b0;
                    mute     <= (head_hz == '0);
                    if (head_ms == '0) begin
                        note_done <= 1'b1;
                        state     <= IDLE;
                    end else if (head_hz == '0) begin
                        state <= PLAY;
                    end else begin
                        state <= DIV;
                    end
                end
                // A zero quotient means the request exceeded CLK_HZ/2; clamp to the fastest tone.
                DIV: if (div_done) begin
                    half  <= (div_q == '0) ? DIV_W'(1) : div_q;
                    state <= PLAY;
                end
                PLAY: begin
                    if (half_cnt == half - DIV_W'(1)) begin
                        half_cnt <= '0;
                        if (!mute) buzzer <= ~buzzer;
                    end else begin
                        half_cnt <= half_cnt + DIV_W'(1);
                    end
                    if (ms_pre == 32'(MS_TICKS - 1)) begin
                        ms_pre  <= '0;
                        ms_left <= ms_left - DUR_W'(1);
                        if (ms_left == DUR_W'(1)) begin
                            buzzer    <= 1'b0;
                            note_done <= 1'b1;
                            half_cnt  <= '0;
`ifdef NOTE_GAP_EN
                            state     <= GAP;
`else
                            state     <= IDLE;
`endif
                        end
                    end else begin
                        ms_pre <= ms_pre + 32'd1;
                    end
                end
`ifdef NOTE_GAP_EN
                // half_cnt is idle outside PLAY, so it doubles as the gap timer.
                GAP: begin
                    if (half_cnt + DIV_W'(1) >= GAP_TICKS) state <= IDLE;
                    else half_cnt <= half_cnt + DIV_W'(1);
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
